// File: rtl/vga_pixel_stream.sv
// VGA pixel output stage: a prefetch FIFO feeds a 2-cycle pipeline that is aligned with the sync levels.
// Optional macro VGA_PIXEL_TEST_PATTERN_EN adds a test_en input that selects 8 vertical colour bars.
module vga_pixel_stream #(
   parameter int REZ_MAX_WIDTH = 11,
   parameter int COLOR_WIDTH   = 12,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [REZ_MAX_WIDTH-1:0] h_count,
   input  logic [REZ_MAX_WIDTH-1:0] v_count,
   input  logic                     h_sync_in,
   input  logic                     v_sync_in,
   input  logic [REZ_MAX_WIDTH-1:0] h_start,
   input  logic [REZ_MAX_WIDTH-1:0] h_len,
   input  logic [REZ_MAX_WIDTH-1:0] v_start,
   input  logic [REZ_MAX_WIDTH-1:0] v_len,
   input  logic [COLOR_WIDTH-1:0]   pix_data,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic                     clr_err,
`ifdef VGA_PIXEL_TEST_PATTERN_EN
   input  logic                     test_en,
`endif
   output logic                     frame_start,
   output logic [COLOR_WIDTH-1:0]   rgb,
   output logic                     h_sync_out,
   output logic                     v_sync_out,
   output logic                     display_en,
   output logic                     underflow_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

   logic [COLOR_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_s;
   logic                   full_s, empty_s, flush_s, push_s, pop_s, uf_s, test_s;
   logic                   h_act_s, v_act_s, active_s;
   logic [REZ_MAX_WIDTH:0] h_end_s, v_end_s;
   logic [COLOR_WIDTH-1:0] s1_data_d, s1_data_q, rgb_q;
   logic                   s1_active_q, s1_hsync_q, s1_vsync_q;
   logic                   display_en_q, h_sync_q, v_sync_q, frame_start_q;
   logic                   underflow_err_d, underflow_err_q;

`ifdef VGA_PIXEL_TEST_PATTERN_EN
   localparam int CH = COLOR_WIDTH / 3;
   logic [REZ_MAX_WIDTH-1:0] bar_off_s;
   logic [COLOR_WIDTH-1:0]   bar_rgb_s;

   function automatic logic [COLOR_WIDTH-1:0] bar_color(input logic [2:0] idx);
      logic [COLOR_WIDTH-1:0] c;
      c = {COLOR_WIDTH{1'b0}};
      c[3*CH-1 -: CH] = {CH{~idx[2]}};
      c[2*CH-1 -: CH] = {CH{~idx[1]}};
      c[CH-1 -: CH]   = {CH{~idx[0]}};
      return c;
   endfunction

   assign test_s    = test_en;
   assign bar_off_s = h_count - h_start;
   assign bar_rgb_s = bar_color(bar_off_s[REZ_MAX_WIDTH-1 -: 3]);
`else
   assign test_s = 1'b0;
`endif

   assign count_s  = wr_ptr_q - rd_ptr_q;
   assign full_s   = (count_s == FULL_CNT);
   assign empty_s  = (wr_ptr_q == rd_ptr_q);
   assign flush_s  = (h_count == {REZ_MAX_WIDTH{1'b0}}) && (v_count == {REZ_MAX_WIDTH{1'b0}});
   assign pix_ready = rst_n && !full_s && !flush_s;

   // Window ends are one bit wider so a window reaching the counter limit does not wrap
   assign h_end_s  = {1'b0, h_start} + {1'b0, h_len};
   assign v_end_s  = {1'b0, v_start} + {1'b0, v_len};
   assign h_act_s  = (h_count >= h_start) && ({1'b0, h_count} < h_end_s);
   assign v_act_s  = (v_count >= v_start) && ({1'b0, v_count} < v_end_s);
   assign active_s = h_act_s && v_act_s;

   // FIFO control, stage-1 data select and sticky error next state
   always_comb begin
      push_s          = pix_valid && pix_ready;
      uf_s            = active_s && !test_s && (empty_s || flush_s);
      pop_s           = active_s && !test_s && !empty_s && !flush_s;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      s1_data_d       = {COLOR_WIDTH{1'b0}};
      underflow_err_d = underflow_err_q;
      if (flush_s) begin
         wr_ptr_d = {(AW+1){1'b0}};
         rd_ptr_d = {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
      if (pop_s) begin
         s1_data_d = mem_q[rd_ptr_q[AW-1:0]];
`ifdef VGA_PIXEL_TEST_PATTERN_EN
      end else if (active_s && test_s) begin
         s1_data_d = bar_rgb_s;
`endif
      end else begin
         s1_data_d = {COLOR_WIDTH{1'b0}};
      end
      if (uf_s) begin
         underflow_err_d = 1'b1;
      end else if (clr_err) begin
         underflow_err_d = 1'b0;
      end else begin
         underflow_err_d = underflow_err_q;
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (push_s && !flush_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= pix_data;
      end
   end

   // Pointers, two pipeline stages and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q        <= {(AW+1){1'b0}};
         rd_ptr_q        <= {(AW+1){1'b0}};
         s1_active_q     <= 1'b0;
         s1_data_q       <= {COLOR_WIDTH{1'b0}};
         s1_hsync_q      <= 1'b0;
         s1_vsync_q      <= 1'b0;
         rgb_q           <= {COLOR_WIDTH{1'b0}};
         display_en_q    <= 1'b0;
         h_sync_q        <= 1'b0;
         v_sync_q        <= 1'b0;
         frame_start_q   <= 1'b0;
         underflow_err_q <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         s1_active_q     <= active_s;
         s1_data_q       <= s1_data_d;
         s1_hsync_q      <= h_sync_in;
         s1_vsync_q      <= v_sync_in;
         rgb_q           <= s1_data_q;
         display_en_q    <= s1_active_q;
         h_sync_q        <= s1_hsync_q;
         v_sync_q        <= s1_vsync_q;
         frame_start_q   <= flush_s;
         underflow_err_q <= underflow_err_d;
      end
   end

   assign rgb           = rgb_q;
   assign display_en    = display_en_q;
   assign h_sync_out    = h_sync_q;
   assign v_sync_out    = v_sync_q;
   assign frame_start   = frame_start_q;
   assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Self-checking bench for vga_pixel_stream: window table, directed corner sequences and a
// randomized phase, all checked against a queue-based reference model.
module tb_vga_pixel_stream;
   localparam int W  = 11;
   localparam int CW = 12;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  h_count, v_count, h_start, h_len, v_start, v_len;
   logic          h_sync_in, v_sync_in, pix_valid, pix_ready, clr_err;
   logic [CW-1:0] pix_data, rgb;
   logic          frame_start, h_sync_out, v_sync_out, display_en, underflow_err;
`ifdef VGA_PIXEL_TEST_PATTERN_EN
   logic          test_en = 1'b0;
`endif

   always #5 clk = ~clk;

   vga_pixel_stream #(.REZ_MAX_WIDTH(W), .COLOR_WIDTH(CW), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .h_start(h_start), .h_len(h_len),
      .v_start(v_start), .v_len(v_len), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .clr_err(clr_err),
`ifdef VGA_PIXEL_TEST_PATTERN_EN
      .test_en(test_en),
`endif
      .frame_start(frame_start), .rgb(rgb), .h_sync_out(h_sync_out),
      .v_sync_out(v_sync_out), .display_en(display_en), .underflow_err(underflow_err)
   );

   typedef struct {
      logic [CW-1:0] rgb;
      logic          de;
      logic          hs;
      logic          vs;
   } res_t;

   typedef struct {
      int h, v, hs, hl, vs, vl;
      logic exp_de;
   } win_vec_t;

   int            n_tests = 0;
   int            n_fail  = 0;
   res_t          pipe_m[$];
   logic [CW-1:0] fifo_m[$];
   logic          err_m, fs_m, last_push;
   logic [CW-1:0] bar_lut [8] = '{12'hFFF, 12'hFF0, 12'hF0F, 12'hF00, 12'h0FF, 12'h0F0, 12'h00F, 12'h000};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      res_t z;
      z.rgb = '0; z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0;
      fifo_m.delete();
      pipe_m.delete();
      pipe_m.push_back(z);
      err_m = 1'b0;
      fs_m  = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rgb"}, rgb, 0);
      chk({tag, "_de"}, display_en, 0);
      chk({tag, "_hs"}, h_sync_out, 0);
      chk({tag, "_vs"}, v_sync_out, 0);
      chk({tag, "_fs"}, frame_start, 0);
      chk({tag, "_err"}, underflow_err, 0);
      chk({tag, "_ready"}, pix_ready, 0);
   endtask

   // One clock: predict from current inputs, check pix_ready, clock, check registered outputs
   task automatic step();
      int   hi, vi;
      logic act, flush, ready, uf, tst;
      res_t r;
      #1;
      hi    = int'(h_count);
      vi    = int'(v_count);
      flush = (hi == 0) && (vi == 0);
      ready = (fifo_m.size() < D) && !flush;
      chk("pix_ready", pix_ready, ready);
      act = (hi >= int'(h_start)) && (hi < int'(h_start) + int'(h_len)) &&
            (vi >= int'(v_start)) && (vi < int'(v_start) + int'(v_len));
      tst = 1'b0;
`ifdef VGA_PIXEL_TEST_PATTERN_EN
      tst = test_en;
`endif
      uf    = act && !tst && (flush || fifo_m.size() == 0);
      r.rgb = '0; r.de = act; r.hs = h_sync_in; r.vs = v_sync_in;
      if (act && !tst && !uf) r.rgb = fifo_m.pop_front();
      if (act && tst) r.rgb = bar_lut[((hi - int'(h_start) + (1 << W)) % (1 << W)) / (1 << (W - 3))];
      last_push = pix_valid && ready;
      if (flush) fifo_m.delete();
      else if (last_push) fifo_m.push_back(pix_data);
      err_m = uf ? 1'b1 : (clr_err ? 1'b0 : err_m);
      fs_m  = flush;
      pipe_m.push_back(r);
      @(posedge clk);
      #1;
      r = pipe_m.pop_front();
      chk("rgb", rgb, r.rgb);
      chk("display_en", display_en, r.de);
      chk("h_sync_out", h_sync_out, r.hs);
      chk("v_sync_out", v_sync_out, r.vs);
      chk("frame_start", frame_start, fs_m);
      chk("underflow_err", underflow_err, err_m);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk_all_zero(tag);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic set_win(input int hs, input int hl, input int vs, input int vl);
      h_start = W'(hs); h_len = W'(hl); v_start = W'(vs); v_len = W'(vl);
   endtask

   initial begin
      win_vec_t wv [12];
      int de_cnt, first_de;
      wv[0]  = '{144, 35, 144, 640, 35, 480, 1'b1};
      wv[1]  = '{143, 35, 144, 640, 35, 480, 1'b0};
      wv[2]  = '{783, 514, 144, 640, 35, 480, 1'b1};
      wv[3]  = '{784, 100, 144, 640, 35, 480, 1'b0};
      wv[4]  = '{200, 515, 144, 640, 35, 480, 1'b0};
      wv[5]  = '{200, 34, 144, 640, 35, 480, 1'b0};
      wv[6]  = '{144, 100, 144, 0, 35, 480, 1'b0};
      wv[7]  = '{300, 100, 144, 640, 35, 0, 1'b0};
      wv[8]  = '{2047, 2047, 2000, 100, 1000, 1100, 1'b1};
      wv[9]  = '{50, 1500, 2000, 100, 1000, 1100, 1'b0};
      wv[10] = '{0, 5, 0, 1, 5, 1, 1'b1};
      wv[11] = '{2046, 7, 0, 2047, 0, 2047, 1'b1};

      rst_n = 1'b0; h_count = W'(1); v_count = W'(1); set_win(144, 640, 35, 480);
      h_sync_in = 1'b0; v_sync_in = 1'b0; pix_valid = 1'b1; pix_data = '0; clr_err = 1'b0;
      #2;

      // Reset release with a valid source: FIFO fills to depth and ready drops
      do_reset("rst0");
      for (int i = 0; i < 8; i++) begin
         pix_data = CW'(i + 1);
         step();
      end
      chk("full_ready_low", pix_ready, 0);
      repeat (2) step();

      // Active-window table
      pix_valid = 1'b0;
      foreach (wv[i]) begin
         h_count = W'(wv[i].h); v_count = W'(wv[i].v);
         set_win(wv[i].hs, wv[i].hl, wv[i].vs, wv[i].vl);
         step();
         step();
         chk($sformatf("win%0d_de", i), display_en, wv[i].exp_de);
      end

      // Flush with 5 words buffered and a valid source
      do_reset("rst1");
      set_win(144, 640, 35, 480); h_count = W'(1); v_count = W'(1); pix_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pix_data = CW'(12'h100 + i);
         step();
      end
      h_count = '0; v_count = '0;
      #1;
      chk("flush_ready_low", pix_ready, 0);
      step();
      chk("frame_start_pulse", frame_start, 1);
      h_count = W'(1); v_count = W'(1); pix_valid = 1'b0;
      step();
      chk("frame_start_one_cycle", frame_start, 0);
      set_win(2, 1, 1, 1); h_count = W'(2);
      step();
      chk("flush_left_empty_err", underflow_err, 1);
      h_count = W'(3);
      step();
      chk("flush_left_empty_rgb", rgb, 0);

      // Source stalls after 3 words; clear only takes once underflows stop
      clr_err = 1'b1; step(); clr_err = 1'b0;
      set_win(20, 10, 2, 4);
      h_count = '0; v_count = '0; step();
      v_count = W'(2);
      for (int h = 1; h <= 32; h++) begin
         h_count = W'(h);
         pix_valid = (h <= 3);
         pix_data = CW'(12'hA0 + h);
         clr_err = (h >= 24);
         step();
         if (h >= 21 && h <= 23) chk("stall_rgb", rgb, 12'hA0 + h - 20);
         if (h == 24) chk("stall_rgb_uf", rgb, 0);
         chk("stall_err", underflow_err, (h >= 23 && h <= 29));
      end
      clr_err = 1'b0;

      // 640x480 window, always-valid in-order source, random sync levels, mid-line reset
      set_win(144, 640, 35, 480); pix_valid = 1'b1; pix_data = '0;
      foreach (wv[i]) if (i < 3) begin
         v_count = (i == 0) ? W'(0) : W'(34 + i);
         de_cnt = 0; first_de = -1;
         for (int h = 0; h < 800; h++) begin
            h_count = W'(h);
            h_sync_in = 1'($urandom); v_sync_in = 1'($urandom);
            step();
            if (last_push) pix_data = pix_data + 1'b1;
            if (display_en) begin
               de_cnt++;
               if (first_de < 0) first_de = h;
            end
            if (i == 2 && h == 300) begin
               rst_n = 1'b0;
               #1;
               chk_all_zero("midline_rst");
               @(posedge clk);
               #1;
               rst_n = 1'b1;
               model_reset();
            end
         end
         if (i == 1) begin
            chk("line_pixels", de_cnt, 640);
            chk("line_first_de", first_de, 145);
            chk("line_no_err", underflow_err, 0);
         end
      end

      // Randomized traffic with small windows so every case is frequent
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0)
            set_win($urandom_range(0, 30), $urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) begin
            h_count = '0; v_count = '0;
         end else begin
            h_count = W'($urandom_range(0, 40)); v_count = W'($urandom_range(0, 5));
         end
         pix_valid = 1'($urandom); pix_data = CW'($urandom);
         clr_err = ($urandom_range(0, 7) == 0);
         h_sync_in = 1'($urandom); v_sync_in = 1'($urandom);
`ifdef VGA_PIXEL_TEST_PATTERN_EN
         test_en = ($urandom_range(0, 3) == 0);
`endif
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_pixel_stream.md
VGA_PIXEL_STREAM -- requirements
Module: vga_pixel_stream

Interface
REQ-001 Parameter REZ_MAX_WIDTH, default 11: width of the h/v counters and window parameters.
REQ-002 Parameter COLOR_WIDTH, default 12: RGB word width (4:4:4).
REQ-003 Parameter FIFO_DEPTH, default 8, power of two >= 4: prefetch FIFO depth in pixels.
REQ-004 clk  in  1  single clock; all state is clocked on the rising edge.
REQ-005 rst_n  in  1  asynchronous reset, active-low.
REQ-006 h_count, v_count  in  REZ_MAX_WIDTH each  horizontal and vertical counter values from the timing counters.
REQ-007 h_sync_in, v_sync_in  in  1 each  sync levels from the timing counters.
REQ-008 h_start, h_len, v_start, v_len  in  REZ_MAX_WIDTH each  active-window origin and size; quasi-static.
REQ-009 pix_data  in  COLOR_WIDTH  pixel from the framebuffer reader.
REQ-010 pix_valid  in  1  pix_data is valid.
REQ-011 pix_ready  out  1  block accepts pix_data this cycle.
REQ-012 clr_err  in  1  clears underflow_err.
REQ-013 frame_start  out  1  one-cycle pulse at frame origin; restarts the reader.
REQ-014 rgb  out  COLOR_WIDTH  pixel colour.
REQ-015 h_sync_out, v_sync_out, display_en  out  1 each  aligned sync levels and active-video flag.
REQ-016 underflow_err  out  1  sticky FIFO-underflow flag.

Function
REQ-017 A push occurs when pix_valid and pix_ready are both high; pix_ready = not full and not flush.
REQ-018 flush is high when h_count == 0 and v_count == 0, combinationally from the current inputs.
REQ-019 A flush empties the FIFO in that cycle; a push offered in the same cycle is not accepted.
REQ-020 frame_start is a registered copy of flush.
REQ-021 active = (h_start <= h_count < h_start+h_len) and (v_start <= v_count < v_start+v_len).
REQ-022 The active sums are computed at REZ_MAX_WIDTH+1 bits with no wrap.
REQ-023 A zero h_len or zero v_len gives active = 0 for the whole frame.
REQ-024 Stage 1 (registered): active_q; pop when active and FIFO not empty; underflow event when active and FIFO empty.
REQ-025 Stage 2 (registered): rgb is the popped word, or zero when not active or on underflow; display_en = active_q.
REQ-026 Total latency input -> output is 2 cycles.
REQ-027 h_sync_out and v_sync_out are h_sync_in and v_sync_in delayed by exactly 2 cycles, so they stay aligned with rgb.
REQ-028 When the FIFO is full, pix_ready = 0 even if a pop occurs in the same cycle; full is the registered full state.
REQ-029 Push and pop when the FIFO is empty: the underflow event is recorded, the pushed word is stored, and the count ends at 1.
REQ-030 Flush during an active pixel: the FIFO is emptied and that pixel takes an underflow.
REQ-031 underflow_err sets on any underflow event and holds until clr_err is high.
REQ-032 When an underflow event and clr_err coincide, set wins.
REQ-033 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.

Reset
REQ-034 On rst_n low, asynchronously clear the FIFO to empty.
REQ-035 On rst_n low, set rgb=0, display_en=0, h_sync_out=0, v_sync_out=0, frame_start=0, underflow_err=0, and clear all pipeline registers.
REQ-036 pix_ready = 0 while rst_n is low.
REQ-037 Reset mid-frame discards buffered pixels; normal operation resumes at the next flush.

Configuration
REQ-038 When macro VGA_PIXEL_TEST_PATTERN_EN is defined, add input test_en (1 bit).
REQ-039 With test_en high, active pixels output 8 vertical colour bars indexed by (h_count-h_start)[REZ_MAX_WIDTH-1 -: 3], with the same 2-cycle latency.
REQ-040 With test_en high, the FIFO is not popped and no underflow is flagged.
REQ-041 When VGA_PIXEL_TEST_PATTERN_EN is undefined, the port is absent and only streamed pixels are output.

Verification
REQ-042 Reset: release rst_n with pix_valid=1 -> all outputs 0 until the first clock, then pix_ready=1, and the FIFO fills to 8 with pix_ready dropping at full.
REQ-043 640x480 window (h_start=144, h_len=640, v_start=35, v_len=480) with an always-valid source -> display_en rises 2 cycles after h_count=144, exactly 640 pixels per line in order, and underflow_err stays 0.
REQ-044 Source stalls after 3 words in an active line -> 3 correct pixels, then rgb=0, and underflow_err=1 on the 4th active pixel; clr_err=1 clears the flag only when no new underflow occurs.
REQ-045 h=0, v=0 with the FIFO holding 5 words and pix_valid=1 -> pix_ready=0 that cycle, FIFO empty after the edge, frame_start=1 for exactly one cycle.
REQ-046 Toggle h_sync_in and v_sync_in at arbitrary cycles -> the outputs follow at exactly +2 cycles; assert rst_n low mid-line -> all outputs 0 immediately.
